// File: rtl/pulse_stretcher_mc_pkg.sv
// Purpose : shared types and constants for the multi-channel pulse stretcher.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: per-channel state enum, retrigger mode constants, blank counter width helper.
package pulse_stretcher_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } chan_state_e;

  localparam logic RETRIG_ON  = 1'b1;
  localparam logic RETRIG_OFF = 1'b0;

  // Width able to hold 0..n, never less than one bit so n = 0 still builds.
  function automatic int blank_w(input int n);
    return (n <= 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_mc_if.sv
// Purpose : bundles the control, trigger and gate signals of pulse_stretcher_mc.
// Latency : n/a (wiring only).
// Backpr. : none; every signal is a level sampled each clock.
// Ports   : master drives polarity_i/enable_i/retrig_i/len_i/pulse_i and observes
//           gate_o/any_o/missed_o/ready_o; slave (the stretcher) is the reverse.
interface pulse_stretcher_mc_if #(
  parameter int NCH   = 8,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]   polarity_i;
  logic [NCH-1:0]   enable_i;
  logic             retrig_i;
  logic [CNT_W-1:0] len_i;
  logic [NCH-1:0]   pulse_i;
  logic [NCH-1:0]   gate_o;
  logic             any_o;
  logic [NCH-1:0]   missed_o;
  logic             ready_o;

  modport master (
    output polarity_i, enable_i, retrig_i, len_i, pulse_i,
    input  gate_o, any_o, missed_o, ready_o
  );

  modport slave (
    input  polarity_i, enable_i, retrig_i, len_i, pulse_i,
    output gate_o, any_o, missed_o, ready_o
  );
endinterface

// File: rtl/pulse_stretcher_mc_chan.sv
// Purpose : one stretcher channel: polarity normalisation, optional edge detect, gate FSM + countdown.
// Latency : trigger sampled at edge k drives gate high from edge k for max(len,1) cycles.
// Backpr. : none; a trigger landing in a non-retriggerable gate is dropped and flagged on missed.
// Ports   : clk_i, reset_i (async, active high); pulse/polarity/enable/retrig/len/ready in;
//           gate, missed out (both registered). Edge mode under PULSE_STRETCHER_EDGE_EN.
module pstr_chan
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pulse,
  input  logic             polarity,
  input  logic             enable,
  input  logic             retrig,
  input  logic [CNT_W-1:0] len,
  input  logic             ready,
  output logic             gate,
  output logic             missed
);

  logic             p;
  logic             hit;
  logic             trig;
  logic [CNT_W-1:0] reload;

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             missed_q, missed_d;

  assign p = pulse ~^ polarity;

`ifdef PULSE_STRETCHER_EDGE_EN
  // prev tracks p every cycle, even while blanked or disabled, so a level
  // already active when the channel becomes eligible never counts as an edge.
  logic p_prev;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) p_prev <= 1'b0;
    else         p_prev <= p;
  end
  assign hit = p & ~p_prev;
`else
  assign hit = p;
`endif

  assign trig = hit & enable & ready;

  // Counter holds remaining cycles after the current one, so a zero length
  // behaves as a single-cycle gate.
  assign reload = (len == '0) ? '0 : len - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    missed_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_d = ST_GATE;
            cnt_d   = reload;
          end
        end
        ST_GATE: begin
          if (trig && (retrig == RETRIG_ON)) begin
            cnt_d = reload;
          end else begin
            // A dropped trigger does not pause the countdown.
            missed_d = trig;
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  assign gate   = (state_q == ST_GATE);
  assign missed = missed_q;

endmodule

// File: rtl/pulse_stretcher_mc.sv
// Purpose : NCH-channel pulse stretcher with post-reset blanking (PULSE_STRETCHER_EDGE_EN selects edge triggering).
// Latency : gate rises at the edge that samples the trigger and stays high max(len_i,1) cycles.
// Backpr. : none; non-retriggerable channels drop in-gate triggers and pulse missed_o.
// Ports   : clk_i, reset_i (async, active high) plus bus (slave modport of pulse_stretcher_mc_if):
//           polarity_i/enable_i/pulse_i per channel, retrig_i, len_i in; gate_o, any_o, missed_o, ready_o out.
module pulse_stretcher_mc
  import pulse_stretcher_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int CNT_W     = 8,
  parameter int BLANK_CYC = 240
) (
  input logic                 clk_i,
  input logic                 reset_i,
  pulse_stretcher_mc_if.slave bus
);

  localparam int BW = blank_w(BLANK_CYC);

  logic [BW-1:0]  blank_cnt;
  logic [BW-1:0]  blank_nxt;
  logic           ready_q;
  logic [NCH-1:0] gate_v;
  logic [NCH-1:0] missed_v;

  // Saturating count of edges since reset release; ready latches on the edge
  // the count reaches BLANK_CYC (the very first edge when BLANK_CYC is 0).
  assign blank_nxt = (blank_cnt == BW'(BLANK_CYC)) ? blank_cnt : blank_cnt + BW'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blank_cnt <= '0;
      ready_q   <= 1'b0;
    end else begin
      blank_cnt <= blank_nxt;
      ready_q   <= ready_q | (blank_nxt == BW'(BLANK_CYC));
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    pstr_chan #(.CNT_W(CNT_W)) u_chan (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .pulse    (bus.pulse_i[c]),
      .polarity (bus.polarity_i[c]),
      .enable   (bus.enable_i[c]),
      .retrig   (bus.retrig_i),
      .len      (bus.len_i),
      .ready    (ready_q),
      .gate     (gate_v[c]),
      .missed   (missed_v[c])
    );
  end

  assign bus.gate_o   = gate_v;
  assign bus.missed_o = missed_v;
  assign bus.any_o    = |gate_v;
  assign bus.ready_o  = ready_q;

endmodule

// File: doc/pulse_stretcher_mc.md
# pulse_stretcher_mc

Multi-channel, parametrised pulse stretcher. It converts short trigger pulses on up to NCH independent inputs of either polarity into positive-logic gates of a run-time programmable length. Supported features:
- retriggerable and non-retriggerable modes;
- per-channel enables;
- a missed-trigger flag;
- a post-reset blanking window.

It sits between asynchronous-origin discrete inputs (already synchronised to clk_i) and the gating and readout logic of the controller.

## Interface
- NCH, 8, number of channels (1..32)
- CNT_W, 8, width of the gate-length counter and len_i
- BLANK_CYC, 240, clocks after reset release during which all triggers are ignored (0 allowed)

- clk_i  in  1  system clock; all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- polarity_i  in  NCH  per channel: 1 = input positive logic, 0 = negative logic
- enable_i  in  NCH  per-channel enable
- retrig_i  in  1  1 = retriggerable, 0 = non-retriggerable (global)
- len_i  in  CNT_W  gate length in clocks; 0 treated as 1
- pulse_i  in  NCH  trigger inputs, synchronous to clk_i
- gate_o  out  NCH  stretched gates, always positive logic, registered
- any_o  out  1  OR of gate_o (combinational from registers)
- missed_o  out  NCH  one-cycle flag: trigger ignored because gate already active
- ready_o  out  1  blanking window finished

## Operation
- Input normalisation: p[c] = pulse_i[c] XNOR polarity_i[c].
- Trigger condition: trig[c] = p[c] & enable_i[c] & ready_o, with the ready_o value from before the edge (see Configuration for edge qualification).
- Blanking counter:
  - width $clog2(BLANK_CYC+1);
  - counts rising edges after reset release and saturates;
  - ready_o registers 1 on the edge at which the count reaches BLANK_CYC;
  - ready_o stays 1 until the next reset.
- Per-channel FSM, states ST_IDLE and ST_GATE, with counter cnt[CNT_W-1:0]. L = max(len_i, 1), sampled only on trigger acceptance.
  - ST_IDLE, trig: go to ST_GATE, cnt <= L-1.
  - ST_GATE, retrig_i=1, trig: stay in ST_GATE, cnt <= L-1 (reload).
  - ST_GATE, retrig_i=0, trig: ignored; missed_o[c] = 1 for that cycle.
  - ST_GATE, no accepted trig, cnt != 0: cnt <= cnt-1.
  - ST_GATE, no accepted trig, cnt == 0: go to ST_IDLE.
- gate_o[c] = (state == ST_GATE).
- enable_i[c] low: the channel goes to ST_IDLE on the next edge, ending any gate in progress; missed_o[c] = 0.
- Changes to len_i or retrig_i during a gate do not alter the current countdown. The new retrig_i value applies to the next trigger evaluation.

## Timing
- Reset values: gate_o = 0, any_o = 0, missed_o = 0, ready_o = 0, all channels ST_IDLE, cnt = 0, blank count = 0.
- Latency: trigger sampled at edge k gives gate_o = 1 from edge k to edge k+L, i.e. exactly L cycles high.
- Retriggerable: the gate ends L cycles after the last accepted trigger.
- Non-retriggerable:
  - at least one low cycle between successive gates;
  - a trigger in the final gate cycle is flagged missed.
- missed_o is registered and asserts at the same edge the ignored trigger is sampled at.
- Reset asserted mid-gate: all outputs drop asynchronously, and blanking restarts on release.

## Configuration
- PULSE_STRETCHER_EDGE_EN defined:
  - the trigger is the rising edge of p[c], via a per-channel prev register that updates every cycle, including during blanking and while disabled;
  - a level held active through blanking or the enable assertion does not trigger;
  - a held level produces exactly one gate.
- PULSE_STRETCHER_EDGE_EN undefined:
  - level-triggered;
  - a held active level gives a continuous gate in retriggerable mode;
  - in non-retriggerable mode it gives L high and 1 low, repeating, with missed_o high on every in-gate cycle.

## Structure
- Package pulse_stretcher_pkg: state enum (ST_IDLE, ST_GATE), mode constants RETRIG_ON/RETRIG_OFF.
- Sub-module pstr_chan: one channel (normalisation, edge detect, FSM, counter, missed flag).
  - Instantiated NCH times via generate.
  - The top holds the blanking counter, ready_o and any_o.

## Test plan
- Blanking: BLANK_CYC=240, pulse_i[0]=1 (pos) from reset release → no gate; ready_o rises at edge 240. Edge build: still no gate. Level build: gate starts at edge 241.
- Length: len_i=5, one-cycle pulse on ch2 → gate_o[2] high exactly 5 cycles starting at the edge after sampling. len_i=0 → 1 cycle.
- Retrigger: len_i=4, retrig_i=1, pulses 3 cycles apart → gate stays high continuously, ending 4 cycles after the last pulse. retrig_i=0 → same stimulus gives 4 high, missed_o on the in-gate pulse, and a second gate only after a low cycle.
- Polarity: polarity_i[1]=0, pulse_i[1] idling high with a 1-cycle low → identical gate to the positive case. Other channels unaffected; any_o tracks the OR.
- Disable/reset mid-gate: enable_i[3] dropped during a gate → gate_o[3]=0 next edge. reset_i pulsed mid-gate → all outputs 0 immediately, ready_o=0, blanking restarts.
